sram_rr_arbiter: RTL
====================

# sram_rr_arbiter

Round-robin arbiter that shares one single-port SRAM macro between NUM_REQ native requesters (AXI4 SRAM FSM, DMA, debug port). Each cycle it grants at most one request, drives the macro, and routes the one-cycle-latency read data back with a per-requester valid. An optional lock holds the grant for short bursts, bounded by a starvation counter.

## Interface
- NUM_REQ, 2, number of requesters (2..8)
- SRAM_WORD_DEPTH, 512, words in the macro; AW = $clog2(SRAM_WORD_DEPTH)
- DATA_WIDTH, 32, word width; BW = DATA_WIDTH/8
- LOCK_MAX, 16, maximum consecutive locked grants before forced release (≥1)

- clk_i  in  1  clock
- rst_n_i  in  1  reset; one clock, asynchronous, active-low
- req_i  in  NUM_REQ  request valid per requester
- lock_i  in  NUM_REQ  keep grant after this request
- we_i  in  NUM_REQ  1 = write, 0 = read
- addr_i  in  NUM_REQ×AW  word address per requester
- wdata_i  in  NUM_REQ×DATA_WIDTH  write data per requester
- be_i  in  NUM_REQ×BW  byte enables per requester
- gnt_o  out  NUM_REQ  one-hot grant; transfer occurs when req_i[k] & gnt_o[k]
- rvalid_o  out  NUM_REQ  read data valid for requester k
- rdata_o  out  DATA_WIDTH  shared read data, qualified by rvalid_o
- sram_en_o  out  1  macro enable
- sram_we_o  out  1  macro write enable
- sram_addr_o  out  AW  macro address
- sram_wdata_o  out  DATA_WIDTH  macro write data
- sram_be_o  out  BW  macro byte enables
- sram_rdata_i  in  DATA_WIDTH  macro read data, valid one cycle after a read enable

## Operation
- States: ARB, LOCKED. Registers: rr pointer ptr (log2 NUM_REQ), lock owner, lock counter, read-return id + valid.
- ARB: grant first asserted req_i scanning ptr, ptr+1, …, wrapping modulo NUM_REQ. On grant to k: ptr ← (k+1) mod NUM_REQ.
- Granted request k with lock_i[k]=1 → LOCKED, owner=k, counter=1.
- LOCKED: only owner eligible. Owner req & lock → grant, counter+1. Owner lock_i=0 → its current request (if any) granted, then ARB. Owner req=0 & lock=1 → no grant to anyone (bubble), counter unchanged.
- Counter reaching LOCK_MAX on a grant → forced return to ARB regardless of lock_i; ptr already past owner, so others get priority.
- lock_i of a non-granted requester ignored.
- Mux: sram_* = granted requester's fields; sram_en_o = any grant; sram_we_o = we_i of granted.
- Reads: registered id; next cycle rvalid_o[id]=1, rdata_o=sram_rdata_i. Writes produce no rvalid.
- Reset mid-operation: all state cleared, in-flight read return dropped.

## Timing
- gnt_o and sram_* combinational from req_i/lock_i and registered state (same-cycle grant, zero-cycle arbitration).
- Read latency: request accepted cycle N → rvalid_o/rdata_o cycle N+1, back-to-back every cycle.
- Reset values: ptr=0, state ARB, counter 0, rvalid_o=0, rdata_o=0; with req_i=0 all gnt_o/sram_* outputs 0.
- Throughput: one access per cycle whenever any eligible request exists.
- Read at cycle N and write to same address at N+1: read returns old data.

## Structure
- Package sram_arb_pkg: state enum (ARB, LOCKED), typedef for per-requester request struct (we, addr, wdata, be) parameterised via localparams AW/DATA_WIDTH defaults.
- Sub-module sram_rr_picker: rotating-priority one-hot picker (req vector, ptr) → one-hot grant + index; instantiated once.
- Top handles FSM, lock counter, mux and read-return register.

## Test plan
- Reset, then req_i=0 40 cycles → gnt_o=0, sram_en_o=0, rvalid_o=0 throughout.
- NUM_REQ=2, both requesters read continuously from addr 0x10/0x20 → grants alternate 0,1,0,1; rvalid_o alternates one cycle later with correct data.
- Requester 0 writes 0xDEADBEEF, be=4'b0011, to 0x1FF; requester 1 reads 0x1FF → rdata_o=0x????BEEF merge of old upper half, rvalid_o[1] only.
- Requester 1 locks for 4 reads while requester 0 requests → four consecutive grants to 1, then grant to 0.
- Lock held 20 cycles with LOCK_MAX=16 and requester 0 pending → forced release after 16th grant, requester 0 granted next cycle.
- Assert rst_n_i in LOCKED with a read in flight → next cycle rvalid_o=0, ptr=0, state ARB.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the round-robin SRAM arbiter.
// The request struct uses the default macro geometry (512 x 32).
package sram_arb_pkg;

  localparam int AW_DEF = 9;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int BW_DEF = DATA_WIDTH_DEF / 8;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                      we;
    logic [AW_DEF-1:0]         addr;
    logic [DATA_WIDTH_DEF-1:0] wdata;
    logic [BW_DEF-1:0]         be;
  } sram_req_t;

  // Increment an index modulo n (n need not be a power of two).
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/sram_rr_picker.sv
// Rotating-priority picker: first set bit of req scanning from ptr upward,
// wrapping modulo N. Returns a one-hot grant, its index and an any-grant flag.
module sram_rr_picker #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  int k;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = 0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = PW'(k);
      end
    end
  end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NUM_REQ requesters,
// with optional bounded lock and one-cycle read-data return routing.
module sram_rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int SRAM_WORD_DEPTH = 512,
  parameter int DATA_WIDTH      = 32,
  parameter int LOCK_MAX        = 16,
  localparam int AW = $clog2(SRAM_WORD_DEPTH),
  localparam int BW = DATA_WIDTH / 8,
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ-1:0]         lock_i,
  input  logic [NUM_REQ-1:0]         we_i,
  input  logic [NUM_REQ*AW-1:0]      addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
  input  logic [NUM_REQ*BW-1:0]      be_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [NUM_REQ-1:0]         rvalid_o,
  output logic [DATA_WIDTH-1:0]      rdata_o,
  output logic                       sram_en_o,
  output logic                       sram_we_o,
  output logic [AW-1:0]              sram_addr_o,
  output logic [DATA_WIDTH-1:0]      sram_wdata_o,
  output logic [BW-1:0]              sram_be_o,
  input  logic [DATA_WIDTH-1:0]      sram_rdata_i,
  output arb_state_e                 dbg_state_o,
  output logic [PW-1:0]              dbg_ptr_o
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  // Handshake: a transfer happens in the cycle where req_i[k] & gnt_o[k];
  // gnt_o is combinational, so requesters need no extra wait state.
  arb_state_e           state;
  logic [PW-1:0]        ptr;
  logic [PW-1:0]        owner;
  logic [CW-1:0]        cnt;
  logic                 rd_vld;
  logic [PW-1:0]        rd_id;

  logic [NUM_REQ-1:0]   elig;
  logic [NUM_REQ-1:0]   gnt;
  logic [PW-1:0]        gnt_idx;
  logic                 gnt_any;
  logic [CW-1:0]        cnt_nxt;
  logic [PW-1:0]        ptr_nxt;

  always_comb begin
    elig = req_i;
    if (state == LOCKED) elig = req_i & (NUM_REQ'(1) << owner);
  end

  sram_rr_picker #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_picker (
    .req (elig),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign gnt_o   = gnt;
  assign cnt_nxt = cnt + CW'(1);
  assign ptr_nxt = PW'(wrap_inc(int'(gnt_idx), NUM_REQ));

  // AND-OR mux: all macro fields fall to zero when nobody is granted.
  always_comb begin
    sram_en_o    = gnt_any;
    sram_we_o    = |(gnt & we_i);
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sram_addr_o  = sram_addr_o  | (addr_i[k*AW +: AW]                 & {AW{gnt[k]}});
      sram_wdata_o = sram_wdata_o | (wdata_i[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{gnt[k]}});
      sram_be_o    = sram_be_o    | (be_i[k*BW +: BW]                   & {BW{gnt[k]}});
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= ARB;
      ptr    <= '0;
      owner  <= '0;
      cnt    <= '0;
      rd_vld <= 1'b0;
      rd_id  <= '0;
    end else begin
      rd_vld <= gnt_any & ~sram_we_o;
      if (gnt_any) rd_id <= gnt_idx;
      case (state)
        ARB: begin
          if (gnt_any) begin
            ptr <= ptr_nxt;
            if (lock_i[gnt_idx] && LOCK_MAX > 1) begin
              state <= LOCKED;
              owner <= gnt_idx;
              cnt   <= CW'(1);
            end
          end
        end
        LOCKED: begin
          // ptr already points past the owner, so release hands priority on.
          if (!lock_i[owner]) begin
            state <= ARB;
            cnt   <= '0;
          end else if (gnt_any) begin
            if (cnt_nxt >= CW'(LOCK_MAX)) begin
              state <= ARB;
              cnt   <= '0;
            end else begin
              cnt <= cnt_nxt;
            end
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  assign rvalid_o    = rd_vld ? (NUM_REQ'(1) << rd_id) : '0;
  assign rdata_o     = rd_vld ? sram_rdata_i : '0;
  assign dbg_state_o = state;
  assign dbg_ptr_o   = ptr;

endmodule
